// File: rtl/bcd_count_pkg.sv
// Shared types and constants for the 3-digit BCD counter and its
// multiplexed 7-segment display.
package bcd_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Common-anode glyphs, bit order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [0:9][6:0] SEG_GLYPH = {
        7'b1000000,
        7'b1111001,
        7'b0100100,
        7'b0110000,
        7'b0011001,
        7'b0010010,
        7'b0000010,
        7'b1111000,
        7'b0000000,
        7'b0010000
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-BCD codes
// are blanked.
module bcd_to_seg7
    import bcd_count_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= BCD_MAX) begin
            seg_o = SEG_GLYPH[bcd_i];
        end
    end

endmodule

// File: rtl/bcd_count_scan_ctrl.sv
// 3-digit BCD event counter with run/pause/done sequencing, tick
// prescaler and round-robin digit scan onto a shared segment bus.
module bcd_count_scan_ctrl
    import bcd_count_pkg::*;
#(
    parameter int TICK_DIV = 10,
    parameter int SCAN_DIV = 4,
    parameter int WRAP     = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       CLEAR,
    output logic [3:0] COUNT_1,
    output logic [3:0] COUNT_10,
    output logic [3:0] COUNT_100,
    output logic       RUNNING,
    output logic       DONE,
    output logic [6:0] SEG,
    output logic [2:0] DIG_SEL
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    u_q, u_d, t_q, t_d, h_q, h_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    dig_q, dig_d;
    logic [6:0]    seg_q, seg_w;
    logic [3:0]    mux_digit;
    logic          tick, at_max, stop_at_max;

    assign tick        = (state_q == ST_RUN) && (pre_q == PRE_LAST);
    assign at_max      = (u_q == BCD_MAX) && (t_q == BCD_MAX)
                         && (h_q == BCD_MAX);
    assign stop_at_max = tick && at_max && (WRAP == 0);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Terminal count outranks a coincident START so DONE cannot be skipped
    always_comb begin
        state_d = state_q;
        if (CLEAR) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (START) state_d = ST_RUN;
                ST_RUN: begin
                    if (stop_at_max)  state_d = ST_DONE;
                    else if (START)   state_d = ST_PAUSE;
                end
                ST_PAUSE: if (START) state_d = ST_RUN;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        RUNNING = (state_q == ST_RUN);
        DONE    = (state_q == ST_DONE);
    end

    always_comb begin
        pre_d = '0;
        if (!CLEAR) begin
            unique case (state_q)
                ST_RUN:   pre_d = tick ? '0 : pre_q + 1'b1;
                ST_PAUSE: pre_d = pre_q;
                default:  pre_d = '0;
            endcase
        end
    end

    always_comb begin
        u_d = u_q;
        t_d = t_q;
        h_d = h_q;
        if (CLEAR) begin
            u_d = '0;
            t_d = '0;
            h_d = '0;
        end else if (tick && !stop_at_max) begin
            u_d = (u_q == BCD_MAX) ? 4'd0 : u_q + 4'd1;
            if (u_q == BCD_MAX) begin
                t_d = (t_q == BCD_MAX) ? 4'd0 : t_q + 4'd1;
                if (t_q == BCD_MAX) begin
                    h_d = (h_q == BCD_MAX) ? 4'd0 : h_q + 4'd1;
                end
            end
        end
    end

    always_comb begin
        scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    always_comb begin
        case (idx_q)
            2'd1:    mux_digit = t_q;
            2'd2:    mux_digit = h_q;
            default: mux_digit = u_q;
        endcase
        dig_d = 3'b111 ^ (3'b001 << idx_q);
    end

    bcd_to_seg7 u_dec (
        .bcd_i (mux_digit),
        .seg_o (seg_w)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre_q  <= '0;
            u_q    <= '0;
            t_q    <= '0;
            h_q    <= '0;
            scan_q <= '0;
            idx_q  <= '0;
            dig_q  <= 3'b110;
            seg_q  <= SEG_GLYPH[0];
        end else begin
            pre_q  <= pre_d;
            u_q    <= u_d;
            t_q    <= t_d;
            h_q    <= h_d;
            scan_q <= scan_d;
            idx_q  <= idx_d;
            dig_q  <= dig_d;
            seg_q  <= seg_w;
        end
    end

    assign COUNT_1   = u_q;
    assign COUNT_10  = t_q;
    assign COUNT_100 = h_q;
    assign SEG       = seg_q;
    assign DIG_SEL   = dig_q;

endmodule

// File: tb/tb_bcd_count_scan_ctrl.sv
// Bench for bcd_count_scan_ctrl: WRAP=0 and WRAP=1 instances driven
// together and compared each cycle against an integer reference model.
module tb_bcd_count_scan_ctrl;

    localparam int TD = 10;
    localparam int SD = 4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       CLEAR = 1'b0;
    logic [3:0] c1[2], c10[2], c100[2];
    logic       run[2], dn[2];
    logic [6:0] seg[2];
    logic [2:0] dsel[2];

    always #5 CLK = ~CLK;

    bcd_count_scan_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD), .WRAP(0)) dut0 (
        .CLK(CLK), .RESET(RESET), .START(START), .CLEAR(CLEAR),
        .COUNT_1(c1[0]), .COUNT_10(c10[0]), .COUNT_100(c100[0]),
        .RUNNING(run[0]), .DONE(dn[0]), .SEG(seg[0]), .DIG_SEL(dsel[0])
    );

    bcd_count_scan_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD), .WRAP(1)) dut1 (
        .CLK(CLK), .RESET(RESET), .START(START), .CLEAR(CLEAR),
        .COUNT_1(c1[1]), .COUNT_10(c10[1]), .COUNT_100(c100[1]),
        .RUNNING(run[1]), .DONE(dn[1]), .SEG(seg[1]), .DIG_SEL(dsel[1])
    );

    int checks = 0;
    int failures = 0;

    // Model: 0 idle, 1 run, 2 pause, 3 done; count as a plain integer
    int st[2], cnt[2], pre[2], pcnt[2];
    int k;
    int gly[10] = '{'h40, 'h79, 'h24, 'h30, 'h19,
                    'h12, 'h02, 'h78, 'h00, 'h10};

    task automatic chk(string tag, int w, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h t=%0t",
                   tag, w, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            st[w] = 0; cnt[w] = 0; pre[w] = 0; pcnt[w] = 0;
        end
        k = 0;
    endfunction

    function automatic void model_edge(bit s, bit c);
        bit tick;
        int ns;
        for (int w = 0; w < 2; w++) begin
            tick = (st[w] == 1) && (pre[w] == TD - 1);
            pcnt[w] = cnt[w];
            if (c) begin
                st[w] = 0; cnt[w] = 0; pre[w] = 0;
            end else begin
                ns = st[w];
                case (st[w])
                    0: if (s) ns = 1;
                    1: begin
                        if (tick && cnt[w] == 999 && w == 0) ns = 3;
                        else if (s) ns = 2;
                    end
                    2: if (s) ns = 1;
                    default: ns = st[w];
                endcase
                if (tick) begin
                    if (cnt[w] == 999) begin
                        if (w == 1) cnt[w] = 0;
                    end else begin
                        cnt[w] = cnt[w] + 1;
                    end
                end
                if (st[w] == 1) pre[w] = tick ? 0 : pre[w] + 1;
                else if (st[w] != 2) pre[w] = 0;
                st[w] = ns;
            end
        end
        k++;
    endfunction

    function automatic int digit_of(int v, int i);
        case (i)
            1: return (v / 10) % 10;
            2: return (v / 100) % 10;
            default: return v % 10;
        endcase
    endfunction

    task automatic compare_all();
        int idx;
        idx = (k == 0) ? 0 : ((k - 1) / SD) % 3;
        for (int w = 0; w < 2; w++) begin
            chk("count_1", w, c1[w], cnt[w] % 10);
            chk("count_10", w, c10[w], (cnt[w] / 10) % 10);
            chk("count_100", w, c100[w], cnt[w] / 100);
            chk("running", w, run[w], st[w] == 1);
            chk("done", w, dn[w], st[w] == 3);
            chk("dig_sel", w, dsel[w], 7 & ~(1 << idx));
            chk("seg", w, seg[w], gly[digit_of(pcnt[w], idx)]);
        end
    endtask

    task automatic step(bit s, bit c);
        START = s;
        CLEAR = c;
        @(posedge CLK);
        model_edge(s, c);
        @(negedge CLK);
        START = 1'b0;
        CLEAR = 1'b0;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
        for (int w = 0; w < 2; w++) begin
            chk("rst_dig", w, dsel[w], 3'b110);
            chk("rst_seg", w, seg[w], 7'b1000000);
            chk("rst_run", w, run[w], 1'b0);
        end
        compare_all();

        repeat (100) step(0, 0);

        step(1, 0);
        chk("start_run", 0, run[0], 1'b1);
        repeat (10) step(0, 0);
        chk("first_tick", 0, c1[0], 4'd1);
        repeat (90) step(0, 0);
        chk("cnt10_units", 0, c1[0], 4'd0);
        chk("cnt10_tens", 0, c10[0], 4'd1);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (dsel[0] == 3'b101) found = 1'b1;
            else step(0, 0);
        end
        chk("tens_sel_seen", 0, found, 1'b1);
        chk("tens_glyph", 0, seg[0], 7'b1111001);

        for (int i = 0; i < 300 && cnt[0] != 23; i++) step(0, 0);
        repeat (3) step(0, 0);
        step(1, 0);
        chk("paused", 0, run[0], 1'b0);
        repeat (50) step(0, 0);
        chk("frozen_u", 0, c1[0], 4'd3);
        chk("frozen_t", 0, c10[0], 4'd2);
        step(1, 0);
        repeat (5) step(0, 0);
        chk("resume_hold", 0, c1[0], 4'd3);
        step(0, 0);
        chk("resume_tick", 0, c1[0], 4'd4);

        repeat (2000) step($urandom_range(0, 39) == 0,
                           $urandom_range(0, 299) == 0);

        step(0, 1);
        step(1, 0);
        repeat (10000) step(0, 0);
        chk("term_done", 0, dn[0], 1'b1);
        chk("term_run", 0, run[0], 1'b0);
        chk("term_hold_h", 0, c100[0], 4'd9);
        chk("term_hold_u", 0, c1[0], 4'd9);
        chk("wrap_run", 1, run[1], 1'b1);
        chk("wrap_zero", 1, c100[1], 4'd0);
        step(1, 0);
        repeat (3) step(0, 0);
        step(1, 0);
        chk("done_ignores_start", 0, dn[0], 1'b1);

        step(0, 1);
        step(1, 0);
        repeat (4573) step(0, 0);
        chk("at457", 0, c100[0], 4'd4);
        step(1, 1);
        chk("clr_run", 0, run[0], 1'b0);
        chk("clr_cnt", 0, c100[0], 4'd0);
        step(1, 0);
        repeat (9) step(0, 0);
        chk("clr_pre_hold", 0, c1[0], 4'd0);
        step(0, 0);
        chk("clr_pre_tick", 0, c1[0], 4'd1);

        step(0, 1);
        step(1, 0);
        repeat (3184) step(0, 0);
        chk("at318", 0, c100[0], 4'd3);
        #2 RESET = 1'b1;
        #1;
        for (int w = 0; w < 2; w++) begin
            chk("async_u", w, c1[w], 4'd0);
            chk("async_h", w, c100[w], 4'd0);
            chk("async_run", w, run[w], 1'b0);
            chk("async_dig", w, dsel[w], 3'b110);
            chk("async_seg", w, seg[w], 7'b1000000);
        end
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        compare_all();
        step(1, 0);
        repeat (10) step(0, 0);
        chk("post_rst_tick", 0, c1[0], 4'd1);
        repeat (20) step(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_count_scan_ctrl.md
Name: bcd_count_scan_ctrl

Overview:
- Controller for the 3-digit BCD event counter (000–999) and its shared 7-segment display.
- Sequences the counter through idle/run/pause/done states using single-cycle START and CLEAR commands.
- Generates the count-enable tick from a prescaler.
- Time-multiplexes the three BCD digits onto one segment bus with a round-robin digit scheduler.

Parameters:
- TICK_DIV, 10, CLK cycles per count tick (≥2).
- SCAN_DIV, 4, CLK cycles each digit is held on the display (≥1).
- WRAP, 0, 1 = 999 rolls to 000 and keeps running; 0 = stop in DONE at 999.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  reset, asynchronous, active-high.
- START  in  1  one-cycle pulse: IDLE/PAUSE→RUN, RUN→PAUSE.
- CLEAR  in  1  one-cycle pulse: zero count, go IDLE.
- COUNT_1  out  4  BCD units.
- COUNT_10  out  4  BCD tens.
- COUNT_100  out  4  BCD hundreds.
- RUNNING  out  1  high in RUN.
- DONE  out  1  high in DONE.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DIG_SEL  out  3  digit enable, one-hot active-low; bit0 = units.

Behaviour:
- Reset values:
  - State IDLE; counts 0/0/0.
  - Prescaler 0; scan counter 0; scan index 0.
  - RUNNING=0, DONE=0.
  - DIG_SEL=3'b110; SEG=7'b1000000 (glyph "0").
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE --START--> RUN.
  - RUN --START--> PAUSE.
  - PAUSE --START--> RUN.
  - RUN --tick at 999, WRAP=0--> DONE.
  - DONE ignores START.
  - Any state --CLEAR--> IDLE.
- CLEAR priority: CLEAR and START in the same cycle → CLEAR wins, START is dropped. CLEAR zeroes the counts and prescaler on the next edge.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN.
  - tick = (prescaler==TICK_DIV-1) && RUN.
  - Holds its value in PAUSE, so resume continues the partial period.
  - Cleared in IDLE and DONE.
  - First tick arrives TICK_DIV cycles after the START edge.
- BCD chain, on tick:
  - Units +1; 9→0.
  - Tens +1 when units==9; 9→0.
  - Hundreds +1 when units==9 && tens==9; 9→0.
  - Counts update on the same edge the tick is registered; no values above 9 are ever produced.
- Terminal count, tick while the count is 999:
  - WRAP=1 → count becomes 000, stays in RUN.
  - WRAP=0 → count holds 999, state becomes DONE, DONE=1 from that edge.
- Outputs: RUNNING and DONE are registered decodes of the state (no extra latency beyond the state register).
- Display scan:
  - Runs in every state, independent of RUN.
  - Scan counter 0..SCAN_DIV-1; at wrap the index advances 0→1→2→0.
  - DIG_SEL and SEG are registered: 1 cycle latency from index/count change.
  - Index 0 shows units, 1 shows tens, 2 shows hundreds.
  - Exactly one DIG_SEL bit is low at all times after reset; no blank cycles.
- Decoder:
  - Standard common-anode glyphs for 0–9.
  - Codes 10–15 are unreachable; they decode to all-off (7'b1111111).
- Reset mid-operation: asynchronous; all outputs return to their reset values immediately, independent of CLK.

Decomposition:
- Package bcd_count_pkg holds:
  - State enum (IDLE, RUN, PAUSE, DONE).
  - BCD_MAX=4'd9.
  - The 10-entry SEG glyph constant table plus SEG_BLANK.
- One sub-module, bcd_to_seg7: combinational 4-bit BCD → 7-bit active-low segment decoder, instantiated once after the digit mux.
- Prescaler, BCD chain, FSM and scan counter stay in the top module.

Test Plan:
- Reset release, no START for 100 cycles → counts 000, RUNNING=0, DIG_SEL cycles 110→101→011 every 4 cycles, SEG=7'b1000000 throughout.
- START pulse, TICK_DIV=10 → RUNNING=1 next edge; COUNT_1=1 after 10 cycles; after 100 cycles count=010 and COUNT_10 shows "1" (SEG=7'b1111001) when DIG_SEL=101.
- START at count 023 (PAUSE), wait 50 cycles, START again → count frozen at 023 during pause; resumed prescaler phase preserved (next increment exactly at remaining period).
- Run to terminal, WRAP=0 → 999 held, DONE=1, RUNNING=0; START pulses ignored. WRAP=1 → next tick gives 000, RUNNING stays 1.
- CLEAR and START in the same cycle while in RUN at 457 → IDLE, count 000, prescaler 0, RUNNING=0.
- Assert RESET asynchronously mid-tick at count 318 → outputs reset before the next CLK edge; a following START counts from 000.
